gpio_port_responder: RTL and testbench

// - Memory-mapped 4-register GPIO port. It is the bus responder (slave) to the CPU's data/address bus initiator.
// - Decodes CS/OE/WE and address[1:0] and drives the 8-bit data bus on reads.
// - Owns one bidirectional pin port: output latch, direction register, input synchronizer,

---
 rtl/gpio_port_responder.sv | 123 ++++++++++++
 tb/tb_gpio_port_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_responder.sv
// Memory-mapped GPIO port: DATA/DIR/FLAG/MASK registers on an 8-bit CPU bus.
// Macro GPIO_PORT_IRQ_EN adds the MASK register and the irq output.
module gpio_port_responder #(
   parameter int         WIDTH       = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RESET_OUT   = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   inout  wire  [7:0]       data,
   input  logic             CS,
   input  logic             OE,
   input  logic             WE,
   inout  wire  [WIDTH-1:0] gpio,
   output logic             irq
);

   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] flag_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] wr_val;
   logic [ARM_W-1:0] arm_q;
   logic             armed;
   logic             wr_en;
   logic [7:0]       rd_data;
   logic [7:0]       mask_rd;

   function automatic logic [7:0] zext(input logic [WIDTH-1:0] v);
      logic [7:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   assign wr_en   = CS & WE;
   assign wr_val  = data[WIDTH-1:0];
   assign sync_in = sync_q[SYNC_STAGES-1];
   assign armed   = (arm_q == ARM_W'(ARM_MAX));
   assign rise    = sync_in & ~prev_q & ~dir_q & {WIDTH{armed}};
   assign clr     = (wr_en && address == 2'd2) ? wr_val : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         prev_q <= sync_in;
      end
   end

   // Edges are ignored until reset-zeroed sync flops have filled with real pin data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         arm_q <= '0;
      else if (!armed)
         arm_q <= arm_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= RESET_OUT[WIDTH-1:0];
         dir_q  <= '0;
         flag_q <= '0;
      end else begin
         flag_q <= (flag_q & ~clr) | rise;
         if (wr_en) begin
            case (address)
               2'd0:    out_q <= wr_val;
               2'd1:    dir_q <= wr_val;
               default: ;
            endcase
         end
      end
   end

`ifdef GPIO_PORT_IRQ_EN
   logic [WIDTH-1:0] mask_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mask_q <= '0;
      else if (wr_en && address == 2'd3)
         mask_q <= wr_val;
   end

   assign mask_rd = zext(mask_q);
   assign irq     = |(flag_q & mask_q);
`else
   assign mask_rd = 8'h00;
   assign irq     = 1'b0;
`endif

   always_comb begin
      rd_data = 8'h00;
      case (address)
         2'd0: rd_data = zext((dir_q & out_q) | (~dir_q & sync_in));
         2'd1: rd_data = zext(dir_q);
         2'd2: rd_data = zext(flag_q);
         2'd3: rd_data = mask_rd;
         default: rd_data = 8'h00;
      endcase
   end

   assign data = (CS & OE) ? rd_data : 8'hzz;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

endmodule

// File: tb/tb_gpio_port_responder.sv
// Bench for gpio_port_responder: pin-history model plus directed literals.
// Honours GPIO_PORT_IRQ_EN the same way as the design.
module tb_gpio_port_responder;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] address = 2'd0;
   logic       CS = 1'b0;
   logic       OE = 1'b0;
   logic       WE = 1'b0;
   logic       bus_en = 1'b0;
   logic [7:0] bus_val = 8'h00;
   logic [7:0] pin_val = 8'h00;
   wire  [7:0] data;
   wire  [7:0] gpio;
   logic       irq;

   int checks = 0;
   int failures = 0;

   // Model state
   logic [7:0] m_out, m_dir, m_flag, m_mask;
   logic [7:0] samp [0:4095];
   int         n;

   gpio_port_responder #(
      .WIDTH(8), .SYNC_STAGES(S), .RESET_OUT(8'h00)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .data(data),
      .CS(CS), .OE(OE), .WE(WE), .gpio(gpio), .irq(irq)
   );

   always #5 clk = ~clk;

   assign data = bus_en ? bus_val : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_drv
      assign gpio[i] = m_dir[i] ? 1'bz : pin_val[i];
   end

   // Pin value seen by the bus after edge n: whatever was on the pin S-1 edges earlier.
   function automatic logic [7:0] pin_seen();
      int idx;
      idx = n - S + 1;
      return (idx >= 1) ? samp[idx] : 8'h00;
   endfunction

   function automatic logic [7:0] model_read(input logic [1:0] a);
      case (a)
         2'd0: return (m_dir & m_out) | (~m_dir & pin_seen());
         2'd1: return m_dir;
         2'd2: return m_flag;
         default: return m_mask;
      endcase
   endfunction

   function automatic logic exp_irq();
      return |(m_flag & m_mask);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_out <= 8'h00; m_dir <= 8'h00;
         m_flag <= 8'h00; m_mask <= 8'h00;
         n <= 0;
      end else begin
         logic [7:0] setb, clrb;
         int e;
         e = n + 1;
         setb = 8'h00;
         // A pin that went 0->1 between samples e-S-1 and e-S raises its flag at edge e.
         if (e >= S + 2)
            setb = samp[e-S] & ~samp[e-S-1] & ~m_dir;
         clrb = (CS && WE && address == 2'd2) ? bus_val : 8'h00;
         m_flag <= (m_flag & ~clrb) | setb;
         samp[e] <= (m_dir & m_out) | (~m_dir & pin_val);
         n <= e;
         if (CS && WE) begin
            if (address == 2'd0) m_out <= bus_val;
            if (address == 2'd1) m_dir <= bus_val;
`ifdef GPIO_PORT_IRQ_EN
            if (address == 2'd3) m_mask <= bus_val;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if (irq !== exp_irq()) begin
            failures++;
            $display("FAIL irq_cycle got=%b exp=%b t=%0t", irq, exp_irq(), $time);
         end
         checks++;
         if ((gpio & m_dir) !== (m_out & m_dir)) begin
            failures++;
            $display("FAIL pins_cycle got=%h exp=%h dir=%h t=%0t",
                     gpio & m_dir, m_out & m_dir, m_dir, $time);
         end
         if (CS && OE) begin
            checks++;
            if (data !== model_read(address)) begin
               failures++;
               $display("FAIL read_cycle a=%0d got=%h exp=%h t=%0t",
                        address, data, model_read(address), $time);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v);
      CS = 1'b1; WE = 1'b1; OE = 1'b0;
      address = a; bus_val = v; bus_en = 1'b1;
      tick();
      CS = 1'b0; WE = 1'b0; bus_en = 1'b0;
   endtask

   task automatic rd_lit(input logic [1:0] a, input logic [7:0] exp, input string name);
      CS = 1'b1; OE = 1'b1; address = a;
      #1;
      chk(name, data, exp);
      CS = 1'b0; OE = 1'b0;
   endtask

   task automatic rd_hold(input logic [1:0] a);
      CS = 1'b1; OE = 1'b1; address = a;
      tick();
      CS = 1'b0; OE = 1'b0;
   endtask

   logic [7:0] irq_on;

   initial begin
`ifdef GPIO_PORT_IRQ_EN
      irq_on = 8'h01;
`else
      irq_on = 8'h00;
`endif
      pin_val = 8'h01;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (6) tick();
      rd_lit(2'd0, 8'h01, "rst_data");
      rd_lit(2'd1, 8'h00, "rst_dir");
      rd_lit(2'd2, 8'h00, "rst_flag_held_pin");
      rd_lit(2'd3, 8'h00, "rst_mask");
      chk("rst_irq", {7'd0, irq}, 8'h00);

      pin_val = 8'h00;
      repeat (4) tick();
      pin_val = 8'h01;
      tick();
      tick();
      rd_lit(2'd2, 8'h00, "flag_k1");
      rd_lit(2'd0, 8'h01, "data_k1");
      tick();
      rd_lit(2'd2, 8'h01, "flag_k2");

      wr(2'd3, 8'h01);
      chk("irq_masked", {7'd0, irq}, irq_on);
      wr(2'd2, 8'h01);
      chk("irq_cleared", {7'd0, irq}, 8'h00);
      rd_lit(2'd2, 8'h00, "flag_w1c");

      pin_val = 8'h00;
      repeat (4) tick();
      pin_val = 8'h01;
      tick();
      tick();
      wr(2'd2, 8'h01);
      rd_lit(2'd2, 8'h01, "flag_set_wins");
      chk("irq_set_wins", {7'd0, irq}, irq_on);
      wr(2'd2, 8'h01);
      rd_lit(2'd2, 8'h00, "flag_clear_again");
      rd_lit(2'd3, irq_on, "mask_read");

      pin_val = 8'h00;
      repeat (4) tick();
      wr(2'd1, 8'h0F);
      wr(2'd0, 8'hA5);
      chk("pins_low", {4'h0, gpio[3:0]}, 8'h05);
      pin_val = 8'hC0;
      tick();
      rd_lit(2'd0, 8'h05, "data_k");
      tick();
      rd_lit(2'd0, 8'hC5, "data_k1_mixed");
      tick();
      rd_lit(2'd2, 8'hC0, "flag_hi_nibble");
      wr(2'd2, 8'hFF);
      rd_lit(2'd2, 8'h00, "flag_clear_all");

      for (int i = 0; i < 16; i++) begin
         pin_val = 8'($urandom);
         rd_hold(2'(i));
      end
      wr(2'd2, 8'hFF);

      CS = 1'b0; WE = 1'b1; address = 2'd1;
      bus_val = 8'hFF; bus_en = 1'b1;
      tick();
      WE = 1'b0; bus_en = 1'b0;
      rd_lit(2'd1, 8'h0F, "cs0_no_write");

      wr(2'd1, 8'hFF);
      wr(2'd0, 8'h3C);
      rd_lit(2'd0, 8'h3C, "data_out_3c");
      chk("pins_3c", gpio, 8'h3C);

      CS = 1'b1; WE = 1'b1; address = 2'd0;
      bus_val = 8'hFF; bus_en = 1'b1;
      #1 reset = 1'b0;
      tick();
      CS = 1'b0; WE = 1'b0; bus_en = 1'b0;
      reset = 1'b1;
      rd_lit(2'd1, 8'h00, "midrst_dir");
      rd_lit(2'd2, 8'h00, "midrst_flag");
      wr(2'd1, 8'hFF);
      rd_lit(2'd0, 8'h00, "midrst_out");
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
